rs_iss_queue: RTL and testbench

Reservation-station issue queue that feeds the execution cluster. Holds dispatched instructions until both source physical registers are ready, wakes them from the CDB tag broadcast produced by the execution units, and sends one ready instruction per cycle through a registered issue stage that drives the `rs2fu_*` inputs of the FU top. It squashes and updates entries on branch recovery or resolution, and halts issue while the FU side asserts its load-commit stall.

---
 rtl/rs_iss_queue.sv | 221 ++++++++++++++++++++++
 tb/tb_rs_iss_queue.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rs_iss_queue.sv
// Reservation-station issue queue: CDB wakeup, lowest-index select into a registered issue stage.
// Optional macro RS_ISS_WAKEUP_BYPASS_EN lets select see the current-cycle CDB tag.
module rs_iss_entry #(
  parameter int PRF_IDX_W = 6,
  parameter int ROB_IDX_W = 5,
  parameter int FU_SEL_W  = 4,
  parameter int BR_MASK_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 iss_clr,
  input  logic [PRF_IDX_W-1:0] dp_opa_tag,
  input  logic [PRF_IDX_W-1:0] dp_opb_tag,
  input  logic                 dp_opa_rdy,
  input  logic                 dp_opb_rdy,
  input  logic [PRF_IDX_W-1:0] dp_dest,
  input  logic [ROB_IDX_W:0]   dp_rob,
  input  logic [31:0]          dp_ir,
  input  logic [FU_SEL_W-1:0]  dp_sel,
  input  logic [63:0]          dp_npc,
  input  logic [BR_MASK_W-1:0] dp_mask,
  input  logic                 cdb_vld,
  input  logic [PRF_IDX_W-1:0] cdb_tag,
  input  logic                 recovery,
  input  logic [BR_MASK_W-1:0] br_fix,
  input  logic [BR_MASK_W-1:0] fix_clr,
  output logic                 vld,
  output logic                 opa_rdy,
  output logic                 opb_rdy,
  output logic [PRF_IDX_W-1:0] opa_tag,
  output logic [PRF_IDX_W-1:0] opb_tag,
  output logic [PRF_IDX_W-1:0] dest,
  output logic [ROB_IDX_W:0]   rob,
  output logic [31:0]          ir,
  output logic [FU_SEL_W-1:0]  sel,
  output logic [63:0]          npc,
  output logic [BR_MASK_W-1:0] mask
);
  always_ff @(posedge clk) begin
    if (rst) begin
      vld     <= 1'b0;
      opa_rdy <= 1'b0;
      opb_rdy <= 1'b0;
    end else if (wr_en) begin
      vld     <= 1'b1;
      opa_rdy <= dp_opa_rdy;
      opb_rdy <= dp_opb_rdy;
    end else begin
      if (cdb_vld && opa_tag == cdb_tag) opa_rdy <= 1'b1;
      if (cdb_vld && opb_tag == cdb_tag) opb_rdy <= 1'b1;
      if (iss_clr || (recovery && |(mask & br_fix))) vld <= 1'b0;
    end
  end

  // Payload needs no reset: it is only observed through a valid entry.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      opa_tag <= dp_opa_tag;
      opb_tag <= dp_opb_tag;
      dest    <= dp_dest;
      rob     <= dp_rob;
      ir      <= dp_ir;
      sel     <= dp_sel;
      npc     <= dp_npc;
      mask    <= dp_mask & ~fix_clr;
    end else begin
      mask    <= mask & ~fix_clr;
    end
  end
endmodule

module rs_iss_queue #(
  parameter int RS_NUM    = 8,
  parameter int PRF_IDX_W = 6,
  parameter int ROB_IDX_W = 5,
  parameter int FU_SEL_W  = 4,
  parameter int BR_MASK_W = 4,
  parameter logic [PRF_IDX_W-1:0] ZERO_REG = '1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dp_en_i,
  input  logic [PRF_IDX_W-1:0] dp_opa_tag_i,
  input  logic [PRF_IDX_W-1:0] dp_opb_tag_i,
  input  logic                 dp_opa_rdy_i,
  input  logic                 dp_opb_rdy_i,
  input  logic [PRF_IDX_W-1:0] dp_dest_tag_i,
  input  logic [ROB_IDX_W:0]   dp_rob_idx_i,
  input  logic [31:0]          dp_IR_i,
  input  logic [FU_SEL_W-1:0]  dp_sel_i,
  input  logic [63:0]          dp_NPC_i,
  input  logic [BR_MASK_W-1:0] dp_br_mask_i,
  input  logic                 cdb_vld_i,
  input  logic [PRF_IDX_W-1:0] cdb_tag_i,
  input  logic                 stall_i,
  input  logic                 rob_br_recovery_i,
  input  logic                 rob_br_pred_correct_i,
  input  logic [BR_MASK_W-1:0] rob_br_tag_fix_i,
  output logic                 rs2fu_iss_vld_o,
  output logic [FU_SEL_W-1:0]  rs2fu_sel_o,
  output logic [31:0]          rs2fu_IR_o,
  output logic [PRF_IDX_W-1:0] rs2fu_dest_tag_o,
  output logic [ROB_IDX_W:0]   rs2fu_rob_idx_o,
  output logic [BR_MASK_W-1:0] rs2fu_br_mask_o,
  output logic [63:0]          rs2fu_NPC_o,
  output logic [PRF_IDX_W-1:0] rs2prf_ra_idx_o,
  output logic [PRF_IDX_W-1:0] rs2prf_rb_idx_o,
  output logic                 rs_full_o
);
  logic [RS_NUM-1:0] e_vld, e_opa_rdy, e_opb_rdy, a_rdy, b_rdy, cand, iss_oh, free_oh;
  logic [RS_NUM-1:0][PRF_IDX_W-1:0] e_opa_tag, e_opb_tag, e_dest;
  logic [RS_NUM-1:0][ROB_IDX_W:0]   e_rob;
  logic [RS_NUM-1:0][31:0]          e_ir;
  logic [RS_NUM-1:0][FU_SEL_W-1:0]  e_sel;
  logic [RS_NUM-1:0][63:0]          e_npc;
  logic [RS_NUM-1:0][BR_MASK_W-1:0] e_mask;

  logic                 dp_go, do_iss, dp_opa_rdy, dp_opb_rdy;
  logic [BR_MASK_W-1:0] fix_clr;
  logic [PRF_IDX_W-1:0] m_opa, m_opb, m_dest;
  logic [ROB_IDX_W:0]   m_rob;
  logic [31:0]          m_ir;
  logic [FU_SEL_W-1:0]  m_sel;
  logic [63:0]          m_npc;
  logic [BR_MASK_W-1:0] m_mask;

  assign rs_full_o  = &e_vld;
  assign fix_clr    = rob_br_pred_correct_i ? rob_br_tag_fix_i : '0;
  assign dp_go      = dp_en_i & ~rs_full_o & ~rob_br_recovery_i;
  assign dp_opa_rdy = dp_opa_rdy_i | (dp_opa_tag_i == ZERO_REG) | (cdb_vld_i & (dp_opa_tag_i == cdb_tag_i));
  assign dp_opb_rdy = dp_opb_rdy_i | (dp_opb_tag_i == ZERO_REG) | (cdb_vld_i & (dp_opb_tag_i == cdb_tag_i));

  // Lowest set bit of cand, lowest clear bit of e_vld. The entry freed this
  // cycle is still valid pre-edge, so dispatch can never land on it.
  assign cand    = e_vld & a_rdy & b_rdy;
  assign iss_oh  = cand & (~cand + RS_NUM'(1));
  assign free_oh = ~e_vld & (e_vld + RS_NUM'(1));
  assign do_iss  = |cand & ~stall_i & ~rob_br_recovery_i;

  for (genvar i = 0; i < RS_NUM; i++) begin : g_ent
`ifdef RS_ISS_WAKEUP_BYPASS_EN
    assign a_rdy[i] = e_opa_rdy[i] | (cdb_vld_i & (e_opa_tag[i] == cdb_tag_i));
    assign b_rdy[i] = e_opb_rdy[i] | (cdb_vld_i & (e_opb_tag[i] == cdb_tag_i));
`else
    assign a_rdy[i] = e_opa_rdy[i];
    assign b_rdy[i] = e_opb_rdy[i];
`endif
    rs_iss_entry #(
      .PRF_IDX_W(PRF_IDX_W), .ROB_IDX_W(ROB_IDX_W),
      .FU_SEL_W(FU_SEL_W), .BR_MASK_W(BR_MASK_W)
    ) u_ent (
      .clk(clk), .rst(rst),
      .wr_en(dp_go & free_oh[i]), .iss_clr(do_iss & iss_oh[i]),
      .dp_opa_tag(dp_opa_tag_i), .dp_opb_tag(dp_opb_tag_i),
      .dp_opa_rdy(dp_opa_rdy), .dp_opb_rdy(dp_opb_rdy),
      .dp_dest(dp_dest_tag_i), .dp_rob(dp_rob_idx_i), .dp_ir(dp_IR_i),
      .dp_sel(dp_sel_i), .dp_npc(dp_NPC_i), .dp_mask(dp_br_mask_i),
      .cdb_vld(cdb_vld_i), .cdb_tag(cdb_tag_i),
      .recovery(rob_br_recovery_i), .br_fix(rob_br_tag_fix_i), .fix_clr(fix_clr),
      .vld(e_vld[i]), .opa_rdy(e_opa_rdy[i]), .opb_rdy(e_opb_rdy[i]),
      .opa_tag(e_opa_tag[i]), .opb_tag(e_opb_tag[i]), .dest(e_dest[i]),
      .rob(e_rob[i]), .ir(e_ir[i]), .sel(e_sel[i]), .npc(e_npc[i]), .mask(e_mask[i])
    );
  end

  always_comb begin
    m_opa  = '0;
    m_opb  = '0;
    m_dest = '0;
    m_rob  = '0;
    m_ir   = '0;
    m_sel  = '0;
    m_npc  = '0;
    m_mask = '0;
    for (int i = 0; i < RS_NUM; i++) begin
      if (iss_oh[i]) begin
        m_opa  = e_opa_tag[i];
        m_opb  = e_opb_tag[i];
        m_dest = e_dest[i];
        m_rob  = e_rob[i];
        m_ir   = e_ir[i];
        m_sel  = e_sel[i];
        m_npc  = e_npc[i];
        m_mask = e_mask[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rs2fu_iss_vld_o  <= 1'b0;
      rs2fu_sel_o      <= '0;
      rs2fu_IR_o       <= '0;
      rs2fu_dest_tag_o <= ZERO_REG;
      rs2fu_rob_idx_o  <= '0;
      rs2fu_br_mask_o  <= '0;
      rs2fu_NPC_o      <= '0;
      rs2prf_ra_idx_o  <= ZERO_REG;
      rs2prf_rb_idx_o  <= ZERO_REG;
    end else begin
      // A squash hits the issue register even while stalled.
      if (rob_br_recovery_i && |(rs2fu_br_mask_o & rob_br_tag_fix_i))
        rs2fu_iss_vld_o <= 1'b0;
      else if (!stall_i)
        rs2fu_iss_vld_o <= do_iss;
      if (do_iss) begin
        rs2fu_sel_o      <= m_sel;
        rs2fu_IR_o       <= m_ir;
        rs2fu_dest_tag_o <= m_dest;
        rs2fu_rob_idx_o  <= m_rob;
        rs2fu_br_mask_o  <= m_mask & ~fix_clr;
        rs2fu_NPC_o      <= m_npc;
        rs2prf_ra_idx_o  <= m_opa;
        rs2prf_rb_idx_o  <= m_opb;
      end else begin
        rs2fu_br_mask_o  <= rs2fu_br_mask_o & ~fix_clr;
      end
    end
  end
endmodule

// File: tb/tb_rs_iss_queue.sv
// Bench for rs_iss_queue: per-cycle vector table, issue scoreboard, multi-cycle corner sequences.
module tb_rs_iss_queue;
  localparam int PW = 6, RW = 5, SW = 4, BW = 4;
  localparam logic [PW-1:0] ZR = '1;

  logic clk, rst, dp_en_i, dp_opa_rdy_i, dp_opb_rdy_i, cdb_vld_i, stall_i;
  logic rob_br_recovery_i, rob_br_pred_correct_i;
  logic [PW-1:0] dp_opa_tag_i, dp_opb_tag_i, dp_dest_tag_i, cdb_tag_i;
  logic [RW:0]   dp_rob_idx_i;
  logic [31:0]   dp_IR_i;
  logic [SW-1:0] dp_sel_i;
  logic [63:0]   dp_NPC_i;
  logic [BW-1:0] dp_br_mask_i, rob_br_tag_fix_i;
  logic          iss_vld, rs_full;
  logic [SW-1:0] iss_sel;
  logic [31:0]   iss_ir;
  logic [PW-1:0] iss_dest, ra_idx, rb_idx;
  logic [RW:0]   iss_rob;
  logic [BW-1:0] iss_mask;
  logic [63:0]   iss_npc;

  rs_iss_queue #(.RS_NUM(8), .PRF_IDX_W(PW), .ROB_IDX_W(RW), .FU_SEL_W(SW), .BR_MASK_W(BW)) dut (
    .clk(clk), .rst(rst), .dp_en_i(dp_en_i),
    .dp_opa_tag_i(dp_opa_tag_i), .dp_opb_tag_i(dp_opb_tag_i),
    .dp_opa_rdy_i(dp_opa_rdy_i), .dp_opb_rdy_i(dp_opb_rdy_i),
    .dp_dest_tag_i(dp_dest_tag_i), .dp_rob_idx_i(dp_rob_idx_i), .dp_IR_i(dp_IR_i),
    .dp_sel_i(dp_sel_i), .dp_NPC_i(dp_NPC_i), .dp_br_mask_i(dp_br_mask_i),
    .cdb_vld_i(cdb_vld_i), .cdb_tag_i(cdb_tag_i), .stall_i(stall_i),
    .rob_br_recovery_i(rob_br_recovery_i), .rob_br_pred_correct_i(rob_br_pred_correct_i),
    .rob_br_tag_fix_i(rob_br_tag_fix_i),
    .rs2fu_iss_vld_o(iss_vld), .rs2fu_sel_o(iss_sel), .rs2fu_IR_o(iss_ir),
    .rs2fu_dest_tag_o(iss_dest), .rs2fu_rob_idx_o(iss_rob), .rs2fu_br_mask_o(iss_mask),
    .rs2fu_NPC_o(iss_npc), .rs2prf_ra_idx_o(ra_idx), .rs2prf_rb_idx_o(rb_idx),
    .rs_full_o(rs_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic dp; logic [PW-1:0] ta, tb; logic ra, rb;
    logic [PW-1:0] dest; logic [RW:0] rob; logic [BW-1:0] mask;
    logic cv; logic [PW-1:0] ct; logic st, rec, corr; logic [BW-1:0] fix;
    logic push; logic ev; logic [PW-1:0] ed; logic [BW-1:0] em;
  } vec_t;
  typedef struct { logic [PW-1:0] dest; logic [RW:0] rob; logic [31:0] ir; } sb_t;

  vec_t tbl[30];
  sb_t  sb[$];
  int   checks = 0, failures = 0;

  function automatic vec_t mk(int dp, int ta, int ra, int tb, int rb, int dest, int rob, int mask,
                              int cv, int ct, int st, int rec, int corr, int fix,
                              int push, int ev, int ed, int em);
    vec_t v;
    v.dp = 1'(dp); v.ta = PW'(ta); v.ra = 1'(ra); v.tb = PW'(tb); v.rb = 1'(rb);
    v.dest = PW'(dest); v.rob = (RW+1)'(rob); v.mask = BW'(mask);
    v.cv = 1'(cv); v.ct = PW'(ct); v.st = 1'(st); v.rec = 1'(rec); v.corr = 1'(corr);
    v.fix = BW'(fix); v.push = 1'(push); v.ev = 1'(ev); v.ed = PW'(ed); v.em = BW'(em);
    return v;
  endfunction

  function automatic vec_t idl(int ev, int ed, int em);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ev, ed, em);
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    dp_en_i = v.dp; dp_opa_tag_i = v.ta; dp_opa_rdy_i = v.ra;
    dp_opb_tag_i = v.tb; dp_opb_rdy_i = v.rb; dp_dest_tag_i = v.dest;
    dp_rob_idx_i = v.rob; dp_br_mask_i = v.mask;
    dp_IR_i = 32'hA000_0000 | 32'(v.dest); dp_NPC_i = 64'h1000 + 64'(v.dest);
    dp_sel_i = v.dest[SW-1:0];
    cdb_vld_i = v.cv; cdb_tag_i = v.ct; stall_i = v.st;
    rob_br_recovery_i = v.rec; rob_br_pred_correct_i = v.corr; rob_br_tag_fix_i = v.fix;
    if (v.push) sb.push_back('{v.dest, v.rob, 32'hA000_0000 | 32'(v.dest)});
  endtask

  // One clock; a newly loaded issue register is matched against the scoreboard.
  task automatic step();
    logic was_vld, was_stall;
    sb_t e;
    was_vld = iss_vld;
    was_stall = stall_i;
    @(posedge clk);
    #1;
    if (iss_vld && !(was_stall && was_vld)) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_issue", 64'(iss_dest), 64'h3f_ffff);
      end else begin
        e = sb.pop_front();
        chk("sb_dest", 64'(iss_dest), 64'(e.dest));
        chk("sb_rob", 64'(iss_rob), 64'(e.rob));
        chk("sb_ir", 64'(iss_ir), 64'(e.ir));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int seen, first, last;
    rst = 1'b1;
    drive(mk(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(); step();
    chk("rst_vld", 64'(iss_vld), 0);
    chk("rst_full", 64'(rs_full), 0);
    chk("rst_dest", 64'(iss_dest), 64'(ZR));
    chk("rst_ra", 64'(ra_idx), 64'(ZR));
    chk("rst_rb", 64'(rb_idx), 64'(ZR));
    chk("rst_rob", 64'(iss_rob), 0);
    chk("rst_mask", 64'(iss_mask), 0);
    chk("rst_ir_npc_sel", {iss_ir, 32'(iss_npc) ^ 32'(iss_sel)}, 0);
    rst = 1'b0;
    drive(idl(0, 0, 0));
    step();

    //          dp ta ra tb rb dest rob mask cv ct st rec corr fix push ev ed em
    tbl[0]  = mk(1, 1, 1, 2, 1, 5, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[1]  = idl(1, 5, 0);
    tbl[2]  = idl(0, 0, 0);
    tbl[3]  = mk(1, 1, 1, 2, 1, 6, 4, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[4]  = mk(1, 1, 1, 2, 1, 7, 5, 0, 0, 0, 0, 0, 0, 0, 1, 1, 6, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 6, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 6, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 6, 0);
    tbl[8]  = idl(1, 7, 0);
    tbl[9]  = idl(0, 0, 0);
    tbl[10] = mk(1, 1, 1, 2, 1, 8, 6, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk(1, 1, 1, 2, 1, 9, 7, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2, 0, 0, 0, 0);
    tbl[13] = idl(1, 9, 1);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 1, 9, 0);
    tbl[15] = idl(0, 0, 0);
    tbl[16] = mk(1, 20, 0, 21, 1, 10, 8, 0, 1, 20, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[17] = idl(1, 10, 0);
    tbl[18] = idl(0, 0, 0);
    tbl[19] = mk(1, 63, 0, 63, 0, 11, 9, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[20] = idl(1, 11, 0);
    tbl[21] = idl(0, 0, 0);
    tbl[22] = mk(1, 1, 1, 2, 1, 12, 10, 4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[23] = idl(1, 12, 4);
    tbl[24] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 4, 0, 0, 0, 0);
    tbl[25] = mk(1, 1, 1, 2, 1, 13, 11, 0, 0, 0, 0, 1, 0, 8, 0, 0, 0, 0);
    tbl[26] = idl(0, 0, 0);
    tbl[27] = mk(1, 1, 1, 2, 1, 14, 11, 3, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    tbl[28] = idl(1, 14, 2);
    tbl[29] = idl(0, 0, 0);

    for (int i = 0; i < 30; i++) begin
      drive(tbl[i]);
      step();
      chk($sformatf("tbl%0d_vld", i), 64'(iss_vld), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d_full", i), 64'(rs_full), 0);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_dest", i), 64'(iss_dest), 64'(tbl[i].ed));
        chk($sformatf("tbl%0d_mask", i), 64'(iss_mask), 64'(tbl[i].em));
      end
    end

    // Wakeup on tag 12
    drive(mk(1, 12, 0, 2, 1, 25, 12, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    step();
    chk("wk_wait", 64'(iss_vld), 0);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
`ifdef RS_ISS_WAKEUP_BYPASS_EN
    chk("wk_edge_c", 64'(iss_vld), 1);
`else
    chk("wk_edge_c", 64'(iss_vld), 0);
`endif
    drive(idl(0, 0, 0));
    step();
`ifdef RS_ISS_WAKEUP_BYPASS_EN
    chk("wk_edge_c1", 64'(iss_vld), 0);
`else
    chk("wk_edge_c1", 64'(iss_vld), 1);
    chk("wk_ra", 64'(ra_idx), 12);
`endif
    step();
    chk("wk_edge_c2", 64'(iss_vld), 0);

    // Fill all 8 entries, drop a 9th, then drain in index order
    for (int i = 0; i < 8; i++) begin
      drive(mk(1, 40, 0, 2, 1, 16 + i, i, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      step();
      chk($sformatf("fill%0d_full", i), 64'(rs_full), (i == 7) ? 1 : 0);
    end
    drive(mk(1, 40, 0, 2, 1, 30, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    chk("fill_drop_full", 64'(rs_full), 1);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 40, 0, 0, 0, 0, 0, 0, 0, 0));
    seen = 0; first = -1; last = -1;
    for (int k = 0; k < 12; k++) begin
      step();
      drive(idl(0, 0, 0));
      if (iss_vld) begin
        seen++;
        if (first < 0) first = k;
        last = k;
      end
    end
    chk("drain_count", 64'(seen), 8);
    chk("drain_consecutive", 64'(last - first), 7);
    chk("drain_full", 64'(rs_full), 0);

    // Reset mid-operation clears a pending entry
    drive(mk(1, 1, 1, 2, 1, 26, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    rst = 1'b1;
    drive(mk(1, 1, 1, 2, 1, 27, 14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    chk("mid_rst_vld", 64'(iss_vld), 0);
    chk("mid_rst_dest", 64'(iss_dest), 64'(ZR));
    rst = 1'b0;
    drive(idl(0, 0, 0));
    step();
    chk("post_rst_vld0", 64'(iss_vld), 0);
    step();
    chk("post_rst_vld1", 64'(iss_vld), 0);
    chk("sb_drain", 64'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
